fc_flatten_loader: RTL and testbench

Upstream stage of the fully connected block. It accepts the final pooling layer's feature stream, one 16-bit value per beat in pixel-major order, and applies an optional ReLU. It reorders the values into the channel-major flattened vector that the first FC layer expects and writes them into the FC word memory at a fixed base address. When the whole vector is stored it pulses `done`, which the FC controller uses as its start/enable.

---
 rtl/fc_pkg.sv | 27 ++
 rtl/flatten_addr_gen.sv | 77 +++++++
 rtl/fc_flatten_loader.sv | 112 +++++++++++
 tb/tb_fc_flatten_loader.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared definitions for the fully connected block: word format, loader FSM
// states and the FC word-memory map.
package fc_pkg;

  localparam int FC_DATA_W = 16;
  localparam int FC_ADDR_W = 14;

  typedef logic signed [FC_DATA_W-1:0] fc_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fill_state_t;

  // FC memory map: flattened input vector, weight matrix, bias vector.
  localparam logic [FC_ADDR_W-1:0] FC_IN_BASE   = 14'h0000;
  localparam int                   FC_IN_WORDS  = 400;
  localparam logic [FC_ADDR_W-1:0] FC_WGT_BASE  = 14'h0200;
  localparam logic [FC_ADDR_W-1:0] FC_BIAS_BASE = 14'h3F00;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/flatten_addr_gen.sv
// Channel-major address generator: nested ch/col/row counters and a running
// address accumulator that avoids any multiplier.
module flatten_addr_gen
  import fc_pkg::*;
#(
  parameter int CHANNELS  = 16,
  parameter int HEIGHT    = 5,
  parameter int WIDTH     = 5,
  parameter int ADDR_W    = FC_ADDR_W,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int NPIX  = HEIGHT * WIDTH;
  localparam int CH_W  = clog2_min1(CHANNELS);
  localparam int ROW_W = clog2_min1(HEIGHT);
  localparam int COL_W = clog2_min1(WIDTH);
  localparam int PIX_W = clog2_min1(NPIX);

  localparam logic [CH_W-1:0]   CH_MAX  = CH_W'(CHANNELS - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0]  COL_MAX = COL_W'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] CH_STEP = ADDR_W'(NPIX);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

  logic [CH_W-1:0]   ch_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic [PIX_W-1:0]  pix_base_q;
  logic [ADDR_W-1:0] addr_acc_q;

  logic             ch_wrap;
  logic             col_wrap;
  logic             row_wrap;
  logic [PIX_W-1:0] pix_next;

  assign ch_wrap  = (ch_q == CH_MAX);
  assign col_wrap = (col_q == COL_MAX);
  assign row_wrap = (row_q == ROW_MAX);
  assign pix_next = (col_wrap && row_wrap) ? '0 : pix_base_q + PIX_W'(1);

  // Channel steps add one feature-map stride; a new pixel reloads from its base.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ch_q       <= '0;
      row_q      <= '0;
      col_q      <= '0;
      pix_base_q <= '0;
      addr_acc_q <= BASE;
    end else if (advance) begin
      if (ch_wrap) begin
        ch_q       <= '0;
        pix_base_q <= pix_next;
        addr_acc_q <= BASE + ADDR_W'(pix_next);
        if (col_wrap) begin
          col_q <= '0;
          row_q <= row_wrap ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end else begin
        ch_q       <= ch_q + CH_W'(1);
        addr_acc_q <= addr_acc_q + CH_STEP;
      end
    end
  end

  assign addr = addr_acc_q;
  assign last = ch_wrap && col_wrap && row_wrap;

endmodule

// File: rtl/fc_flatten_loader.sv
// Loads the pixel-major pooling stream into FC memory as a channel-major
// flattened vector, with optional ReLU, and pulses done when complete.
module fc_flatten_loader
  import fc_pkg::*;
#(
  parameter int CHANNELS  = 16,
  parameter int HEIGHT    = 5,
  parameter int WIDTH     = 5,
  parameter int DATA_W    = FC_DATA_W,
  parameter int ADDR_W    = FC_ADDR_W,
  parameter int BASE_ADDR = int'(FC_IN_BASE),
  parameter int RELU      = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic        [ADDR_W-1:0] mem_addr,
  output logic signed [DATA_W-1:0] mem_wdata,
  output logic                     busy,
  output logic                     done
);

  if (longint'(BASE_ADDR) + longint'(CHANNELS) * longint'(HEIGHT) * longint'(WIDTH)
      > (longint'(1) << ADDR_W)) begin : g_map_overflow
    $error("fc_flatten_loader: flattened vector does not fit in FC memory");
  end

  function automatic logic signed [DATA_W-1:0] relu_fn(input logic signed [DATA_W-1:0] x);
    if ((RELU != 0) && x[DATA_W-1]) return '0;
    return x;
  endfunction

  fill_state_t state_q;
  fill_state_t state_d;

  logic              gen_last;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_clear;

  logic                     vld_p0;
  logic        [ADDR_W-1:0] addr_p0;
  logic signed [DATA_W-1:0] data_p0;

  logic                     vld_p1;
  logic        [ADDR_W-1:0] addr_p1;
  logic signed [DATA_W-1:0] data_p1;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FILL;
      FILL:    if (vld_p0 && gen_last) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == FILL);
  assign busy      = (state_q == FILL) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign gen_clear = (state_q == IDLE) && start;

  flatten_addr_gen #(
    .CHANNELS (CHANNELS),
    .HEIGHT   (HEIGHT),
    .WIDTH    (WIDTH),
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR)
  ) u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .clear  (gen_clear),
    .advance(vld_p0),
    .addr   (gen_addr),
    .last   (gen_last)
  );

  // Stage p0: accepted beat with its target address and activated value.
  assign vld_p0  = in_ready && in_valid;
  assign addr_p0 = gen_addr;
  assign data_p0 = relu_fn(in_data);

  // Stage p1: registered memory write port; address/data hold between writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        addr_p1 <= addr_p0;
        data_p1 <= data_p0;
      end
    end
  end

  assign mem_we    = vld_p1;
  assign mem_addr  = addr_p1;
  assign mem_wdata = data_p1;

endmodule

// File: tb/tb_fc_flatten_loader.sv
// Directed/random bench for fc_flatten_loader across three parameter sets,
// checked against a flattening reference computed from row/col/channel indices.
module tb_fc_flatten_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [15:0] in_data;
  logic [1:0]  sel;

  logic [2:0]  start_v;
  logic [2:0]  valid_v;
  wire  [2:0]  ready_w;
  wire  [2:0]  we_w;
  wire  [2:0]  busy_w;
  wire  [2:0]  done_w;
  logic [13:0] addr_w  [3];
  logic [15:0] wdata_w [3];

  int cfg_ch   [3] = '{16, 16, 120};
  int cfg_h    [3] = '{5, 5, 1};
  int cfg_w    [3] = '{5, 5, 1};
  int cfg_base [3] = '{0, 0, 256};
  int cfg_relu [3] = '{1, 0, 1};

  int n_eval = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always_comb begin
    start_v      = '0;
    valid_v      = '0;
    start_v[sel] = start;
    valid_v[sel] = in_valid;
  end

  fc_flatten_loader dut_a (
    .clk(clk), .reset(reset), .start(start_v[0]), .in_valid(valid_v[0]), .in_data(in_data),
    .in_ready(ready_w[0]), .mem_we(we_w[0]), .mem_addr(addr_w[0]), .mem_wdata(wdata_w[0]),
    .busy(busy_w[0]), .done(done_w[0])
  );

  fc_flatten_loader #(.RELU(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_v[1]), .in_valid(valid_v[1]), .in_data(in_data),
    .in_ready(ready_w[1]), .mem_we(we_w[1]), .mem_addr(addr_w[1]), .mem_wdata(wdata_w[1]),
    .busy(busy_w[1]), .done(done_w[1])
  );

  fc_flatten_loader #(.CHANNELS(120), .HEIGHT(1), .WIDTH(1), .BASE_ADDR(256)) dut_c (
    .clk(clk), .reset(reset), .start(start_v[2]), .in_valid(valid_v[2]), .in_data(in_data),
    .in_ready(ready_w[2]), .mem_we(we_w[2]), .mem_addr(addr_w[2]), .mem_wdata(wdata_w[2]),
    .busy(busy_w[2]), .done(done_w[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Beat k arrives as channel (k mod C) of pixel (k div C), pixels row-major.
  function automatic logic [31:0] ref_addr(input int k);
    int c, h, w, pix, ch, row, col;
    c   = cfg_ch[sel];
    h   = cfg_h[sel];
    w   = cfg_w[sel];
    pix = k / c;
    ch  = k % c;
    row = pix / w;
    col = pix % w;
    return 32'(cfg_base[sel] + ch * h * w + row * w + col);
  endfunction

  function automatic logic [31:0] ref_data(input logic [15:0] d);
    if (cfg_relu[sel] != 0 && d[15]) return 32'h0;
    return {16'h0, d};
  endfunction

  task automatic chk_all_reset(input string tag);
    chk_bit({tag, "_ready"}, ready_w[sel], 1'b0);
    chk_bit({tag, "_we"},    we_w[sel],    1'b0);
    chk_val({tag, "_addr"},  {18'h0, addr_w[sel]},  32'h0);
    chk_val({tag, "_wdata"}, {16'h0, wdata_w[sel]}, 32'h0);
    chk_bit({tag, "_busy"},  busy_w[sel],  1'b0);
    chk_bit({tag, "_done"},  done_w[sel],  1'b0);
  endtask

  // mode 0: data = beat index; mode 1: mix of 0x8005, 0x7FFF and random words.
  task automatic fill(input int dens, input int mode, input int abort_at, input bit mid_start);
    int          n, k, cyc, r;
    bit          v;
    logic [15:0] d;
    n   = cfg_ch[sel] * cfg_h[sel] * cfg_w[sel];
    k   = 0;
    cyc = 0;
    start = 1'b1; in_valid = 1'b0;
    tick();
    start = 1'b0;
    chk_bit("arm_busy",  busy_w[sel],  1'b1);
    chk_bit("arm_ready", ready_w[sel], 1'b1);
    chk_bit("arm_we",    we_w[sel],    1'b0);
    while (k < n) begin
      if (cyc >= n * 20) begin
        chk_val("fill_timeout", 32'(k), 32'(n));
        break;
      end
      v = ($urandom_range(99) < dens);
      if (mode == 0) d = 16'(k);
      else begin
        r = int'($urandom_range(3));
        d = (r == 0) ? 16'h8005 : (r == 1) ? 16'h7FFF : 16'($urandom);
      end
      in_valid = v;
      in_data  = d;
      if (abort_at >= 0 && k == abort_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        chk_all_reset("abort");
        tick();
        chk_bit("abort_idle_ready", ready_w[sel], 1'b0);
        chk_bit("abort_idle_we",    we_w[sel],    1'b0);
        return;
      end
      start = mid_start && (k == 20);
      tick();
      cyc++;
      start = 1'b0;
      chk_bit("wr_we", we_w[sel], v);
      if (v) begin
        chk_val("wr_addr",  {18'h0, addr_w[sel]},  ref_addr(k));
        chk_val("wr_wdata", {16'h0, wdata_w[sel]}, ref_data(d));
        k++;
      end
      if (k < n) chk_bit("fill_ready", ready_w[sel], 1'b1);
    end
    if (k == n) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      chk_bit("drain_ready", ready_w[sel], 1'b0);
      chk_bit("drain_busy",  busy_w[sel],  1'b1);
      chk_bit("drain_done",  done_w[sel],  1'b0);
      tick();
      chk_bit("done_pulse", done_w[sel],  1'b1);
      chk_bit("done_we",    we_w[sel],    1'b0);
      chk_bit("done_busy",  busy_w[sel],  1'b0);
      chk_bit("done_ready", ready_w[sel], 1'b0);
      tick();
      chk_bit("post_done",  done_w[sel],  1'b0);
      chk_bit("post_ready", ready_w[sel], 1'b0);
      chk_bit("post_we",    we_w[sel],    1'b0);
      tick();
      chk_bit("extra_we",    we_w[sel],    1'b0);
      chk_bit("extra_ready", ready_w[sel], 1'b0);
      in_valid = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 16'h0; sel = 2'd0;
    tick(); tick(); tick();
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      chk_all_reset("reset");
    end
    reset = 1'b0;
    sel   = 2'd0;

    // Valid beats without start are never taken.
    in_valid = 1'b1; in_data = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_bit("idle_ready", ready_w[sel], 1'b0);
      chk_bit("idle_we",    we_w[sel],    1'b0);
      chk_bit("idle_busy",  busy_w[sel],  1'b0);
    end
    in_valid = 1'b0;

    sel = 2'd0; fill(100, 0, -1, 1'b0);
    sel = 2'd0; fill(50, 1, -1, 1'b1);
    sel = 2'd1; fill(70, 1, -1, 1'b0);
    sel = 2'd0; fill(100, 0, 37, 1'b1);
    sel = 2'd0; fill(100, 1, -1, 1'b0);
    sel = 2'd2; fill(60, 1, -1, 1'b0);
    sel = 2'd2; fill(100, 0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
